// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one external combinational booth multiplier
// among NUM_REQ valid/ready requesters and returns tagged products on one response channel.
module booth_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             mul_a,
  output logic [7:0]             mul_b,
  input  logic [15:0]            mul_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            rsp_c,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     c;
  } rsp_t;

  state_t                      state;
  rsp_t                        rsp_q;
  logic [ID_W-1:0]             rr_ptr;
  logic [ID_W-1:0]             grant_id;
  logic [ID_W-1:0]             gnt_id;
  logic [ID_W-1:0]             idx;
  logic                        gnt_hit;
  logic [NUM_REQ-1:0][7:0]     a_v;
  logic [NUM_REQ-1:0][7:0]     b_v;

  assign a_v = req_a;
  assign b_v = req_b;

  // Search starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_id  = '0;
    idx     = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == ID_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
      if (!gnt_hit && req_valid[idx]) begin
        gnt_hit = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign req_ready = (state == IDLE && gnt_hit) ? (NUM_REQ'(1) << gnt_id) : '0;
  assign busy      = (state != IDLE);
  assign rsp_id    = rsp_q.id;
  assign rsp_c     = rsp_q.c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mul_a     <= '0;
      mul_b     <= '0;
      grant_id  <= '0;
      rr_ptr    <= ID_W'(NUM_REQ-1);
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_hit) begin
          mul_a    <= a_v[gnt_id];
          mul_b    <= b_v[gnt_id];
          grant_id <= gnt_id;
          rr_ptr   <= gnt_id;
          state    <= ISSUE;
        end
        // Operands have been stable for the whole cycle; product is settled at this edge.
        ISSUE: begin
          rsp_q.c   <= mul_c;
          rsp_q.id  <= grant_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter; the external multiplier is modelled inline.
module tb_booth_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           mul_a, mul_b;
  logic [15:0]          mul_c;
  logic                 rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_c;
  logic signed [15:0]   sa, sb;

  int checks = 0;
  int errors = 0;

  booth_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Sign-extend to 16 bits; the low 16 bits of the product are exact for 8x8 signed.
  assign sa    = {{8{mul_a[7]}}, mul_a};
  assign sb    = {{8{mul_b[7]}}, mul_b};
  assign mul_c = sa * sb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setop(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  // One uncontended operation on requester i, starting and ending in IDLE.
  task automatic do_op(input string tag, input int i, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp_c);
    setop(i, a, b);
    req_valid = NUM_REQ'(1) << i;
    #1;
    chk({tag, ".ready"}, 16'(req_ready), 16'(NUM_REQ'(1) << i));
    tick();
    chk({tag, ".busy_issue"}, 16'(busy), 16'd1);
    chk({tag, ".mul_a"}, 16'(mul_a), 16'(a));
    chk({tag, ".mul_b"}, 16'(mul_b), 16'(b));
    chk({tag, ".ready_issue"}, 16'(req_ready), 16'd0);
    req_valid = '0;
    tick();
    chk({tag, ".rsp_valid"}, 16'(rsp_valid), 16'd1);
    chk({tag, ".rsp_c"}, rsp_c, exp_c);
    chk({tag, ".rsp_id"}, 16'(rsp_id), 16'(i));
    chk({tag, ".busy_resp"}, 16'(busy), 16'd1);
    tick();
    chk({tag, ".rsp_done"}, 16'(rsp_valid), 16'd0);
    chk({tag, ".busy_idle"}, 16'(busy), 16'd0);
  endtask

  logic [7:0]  ta [4];
  logic [7:0]  tb_ [4];
  logic [15:0] tc [4];
  int          ord [5];

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    tick(); tick();
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst.mul_a", 16'(mul_a), 16'd0);
    chk("rst.rsp_c", rsp_c, 16'd0);
    rst_n = 1'b1;
    tick();

    // 1: single request 15*3
    do_op("t1", 0, 8'd15, 8'd3, 16'd45);

    // 2: signed operands on requester 2
    do_op("t2a", 2, 8'd12, 8'hFB, 16'hFFC4);   // 12*-5 = -60
    do_op("t2b", 2, 8'hF9, 8'hF7, 16'h003F);   // -7*-9 = 63
    do_op("t2c", 2, 8'h7F, 8'h80, 16'hC080);   // 127*-128 = -16256

    // 3: all requesters valid from reset -> 0,1,2,3,0
    ta  = '{8'h01, 8'h03, 8'h05, 8'hF9};
    tb_ = '{8'h02, 8'hFC, 8'h06, 8'h08};
    tc  = '{16'h0002, 16'hFFF4, 16'h001E, 16'hFFC8};  // 2, -12, 30, -56
    ord = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) setop(i, ta[i], tb_[i]);
    req_valid = 4'b1111;
    tick();
    rst_n = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("t3.ready%0d", n), 16'(req_ready), 16'(4'b0001 << ord[n]));
      tick();
      chk($sformatf("t3.ready_issue%0d", n), 16'(req_ready), 16'd0);
      tick();
      chk($sformatf("t3.rsp_id%0d", n), 16'(rsp_id), 16'(ord[n]));
      chk($sformatf("t3.rsp_c%0d", n), rsp_c, tc[ord[n]]);
      tick();
    end

    // 4: backpressure with requester 1 pending (last winner was 0)
    req_valid = 4'b0001;
    setop(0, 8'h01, 8'h02);
    req_valid = 4'b0000;
    req_valid[0] = 1'b1;
    #1;
    chk("t4.ready0", 16'(req_ready), 16'b0010 & 16'd0 | 16'd1);
    tick();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    tick();
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("t4.rsp_valid%0d", n), 16'(rsp_valid), 16'd1);
      chk($sformatf("t4.rsp_c%0d", n), rsp_c, 16'h0002);
      chk($sformatf("t4.rsp_id%0d", n), 16'(rsp_id), 16'd0);
      chk($sformatf("t4.ready%0d", n), 16'(req_ready), 16'd0);
      if (n < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4.rsp_drop", 16'(rsp_valid), 16'd0);
    chk("t4.ready1", 16'(req_ready), 16'b0010);
    tick();
    chk("t4.mul_a1", 16'(mul_a), 16'h0003);
    req_valid = '0;
    tick();
    chk("t4.rsp_c1", rsp_c, 16'hFFF4);
    chk("t4.rsp_id1", 16'(rsp_id), 16'd1);
    tick();

    // 5: reset during ISSUE for -8*6
    setop(0, 8'hF8, 8'h06);
    req_valid = 4'b0001;
    tick();
    chk("t5.busy", 16'(busy), 16'd1);
    chk("t5.mul_a", 16'(mul_a), 16'h00F8);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("t5.rst_busy", 16'(busy), 16'd0);
    chk("t5.rst_mul_a", 16'(mul_a), 16'd0);
    chk("t5.rst_mul_b", 16'(mul_b), 16'd0);
    chk("t5.rst_rsp_c", rsp_c, 16'd0);
    tick(); tick();
    chk("t5.no_rsp", 16'(rsp_valid), 16'd0);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("t5.prio0", 16'(req_ready), 16'b0001);
    req_valid = '0;
    tick();
    chk("t5.still_idle", 16'(busy), 16'd0);
    chk("t5.no_rsp2", 16'(rsp_valid), 16'd0);

    // 6: edge values, then operands hold while idle
    do_op("t6a", 0, 8'h80, 8'h80, 16'h4000);   // -128*-128 = 16384
    do_op("t6b", 1, 8'h00, 8'd25, 16'h0000);
    setop(1, 8'h55, 8'h66);
    tick(); tick();
    chk("t6.hold_a", 16'(mul_a), 16'h0000);
    chk("t6.hold_b", 16'(mul_b), 16'd25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
